sub3_pipe: RTL and testbench

Two-stage pipelined three-operand subtractor computing D = A − B − C on N-bit two's-complement samples, with valid/ready flow control and an overflow flag. It is the difference-side counterpart of the registered three-operand adder in the FFT butterfly datapath: where the adder forms the sum leg, this block forms the difference leg. Streaming butterfly stages that must tolerate backpressure from downstream use it.

---
 rtl/sub3_pipe.sv | 99 +++++++++
 tb/tb_sub3_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub3_pipe.sv
// Two-stage pipelined three-operand subtractor D = A - B - C with valid/ready flow control.
// Optional build macro SUB3_SAT_EN: saturate D on overflow instead of wrapping.
module sub3_pipe #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] C,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] D,
    output logic         out_ovf
);

    localparam int W = N + 2;

    logic         r_s1_valid;
    logic [W-1:0] r_s1_diff;
    logic [N-1:0] r_s1_c;
    logic         r_out_valid;
    logic [N-1:0] r_d;
    logic         r_ovf;

    logic         w_s2_load;
    logic         w_s1_load;
    logic         w_fire;
    logic [W-1:0] w_a_ext;
    logic [W-1:0] w_b_ext;
    logic [W-1:0] w_c_ext;
    logic [W-1:0] w_diff1;
    logic [W-1:0] w_exact;
    logic         w_ovf;
    logic [N-1:0] w_d_next;

    // Stage 2 frees up when empty or being drained; stage 1 then drains into it.
    assign w_s2_load = !r_out_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load && !rst;
    assign w_fire    = in_valid && in_ready;

    assign w_a_ext = {{2{A[N-1]}}, A};
    assign w_b_ext = {{2{B[N-1]}}, B};
    assign w_c_ext = {{2{r_s1_c[N-1]}}, r_s1_c};
    assign w_diff1 = w_a_ext - w_b_ext;
    assign w_exact = r_s1_diff - w_c_ext;

    // Result fits in N signed bits only when the top three bits agree.
    assign w_ovf = !((&w_exact[W-1:N-1]) || !(|w_exact[W-1:N-1]));

    always_comb begin
        w_d_next = w_exact[N-1:0];
`ifdef SUB3_SAT_EN
        if (w_ovf) begin
            if (w_exact[W-1]) begin
                w_d_next = {1'b1, {(N-1){1'b0}}};
            end else begin
                w_d_next = {1'b0, {(N-1){1'b1}}};
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_diff  <= '0;
            r_s1_c     <= '0;
        end else if (w_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_diff  <= w_diff1;
            r_s1_c     <= C;
        end else if (w_s1_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_d         <= '0;
            r_ovf       <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_d   <= w_d_next;
                r_ovf <= w_ovf;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign D         = r_d;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_sub3_pipe.sv
// Self-checking bench for sub3_pipe: directed tests plus a scoreboard-driven output monitor.
// Expected D values follow SUB3_SAT_EN when the bench is built with it.
module tb_sub3_pipe;

    localparam int N = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] C;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] D;
    logic         out_ovf;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    logic [N:0] sb[$];

    sub3_pipe #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .C         (C),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact difference in 64 bits, then overflow/saturate/wrap.
    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [N-1:0] c);
        longint     ex;
        longint     maxv;
        longint     minv;
        logic [63:0] exu;
        logic       ovf;
        logic [N-1:0] d;
        ex   = longint'($signed(a)) - longint'($signed(b)) - longint'($signed(c));
        maxv = (longint'(1) << (N - 1)) - 1;
        minv = -(longint'(1) << (N - 1));
        ovf  = (ex > maxv) || (ex < minv);
        exu  = ex;
        d    = exu[N-1:0];
`ifdef SUB3_SAT_EN
        if (ex > maxv) begin
            exu = maxv;
            d   = exu[N-1:0];
        end else if (ex < minv) begin
            exu = minv;
            d   = exu[N-1:0];
        end
`endif
        return {ovf, d};
    endfunction

    // Monitor: pop on every output handshake, push on every input handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got D=%h ovf=%b, required no output", D, out_ovf);
                end else begin
                    logic [N:0] exp;
                    exp = sb.pop_front();
                    pops++;
                    if ({out_ovf, D} !== exp) begin
                        errors++;
                        $display("FAIL sb_result: got ovf=%b D=%h, required ovf=%b D=%h",
                                 out_ovf, D, exp[N], exp[N-1:0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(A, B, C));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; C = '0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || D !== '0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b D=%h ovf=%b, required 0/0000/0", out_valid, D, out_ovf);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1; A = 16'd100; B = 16'd30; C = 16'd20;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_early: got out_valid=%b, required 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || D !== 16'h0032 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL single_result: got v=%b D=%h ovf=%b, required 1/0032/0", out_valid, D, out_ovf);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_pulse: got out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_neg_ovf();
        logic [N-1:0] exp_d;
`ifdef SUB3_SAT_EN
        exp_d = 16'h8000;
`else
        exp_d = 16'h7FFE;
`endif
        in_valid = 1'b1; A = 16'h8000; B = 16'h0001; C = 16'h0001;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || D !== exp_d || out_ovf !== 1'b1) begin
            errors++;
            $display("FAIL neg_ovf: got v=%b D=%h ovf=%b, required 1/%h/1", out_valid, D, out_ovf, exp_d);
        end
        tick();
    endtask

    task automatic test_pos_ovf();
        logic [N-1:0] exp_d;
`ifdef SUB3_SAT_EN
        exp_d = 16'h7FFF;
`else
        exp_d = 16'hFFFF;
`endif
        in_valid = 1'b1; A = 16'h7FFF; B = 16'h8000; C = 16'h0000;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || D !== exp_d || out_ovf !== 1'b1) begin
            errors++;
            $display("FAIL pos_ovf: got v=%b D=%h ovf=%b, required 1/%h/1", out_valid, D, out_ovf, exp_d);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [N:0] exp1;
        int start_pops;
        int n;
        start_pops = pops;
        exp1 = model(16'd1000, 16'd7, 16'd3);
        out_ready = 1'b0;
        in_valid = 1'b1; A = 16'd1000; B = 16'd7; C = 16'd3;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_accept1: got in_ready=%b, required 1", in_ready);
        end
        tick();
        A = 16'hFF00; B = 16'd5; C = 16'h0100;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_accept2: got in_ready=%b, required 1", in_ready);
        end
        tick();
        A = 16'h1234; B = 16'h0034; C = 16'h0200;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_ovf, D} !== exp1) begin
                errors++;
                $display("FAIL bp_stall: got rdy=%b v=%b ovf=%b D=%h, required 0/1/%b/%h",
                         in_ready, out_valid, out_ovf, D, exp1[N], exp1[N-1:0]);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: got in_ready=%b, required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n = 0;
        while ((out_valid || sb.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (pops - start_pops != 3 || sb.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: got %0d results (%0d pending), required 3 (0 pending)",
                     pops - start_pops, sb.size());
        end
    endtask

    task automatic test_stream();
        int start_pops;
        int n;
        int not_ready;
        start_pops = pops;
        not_ready = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            A = N'($urandom()); B = N'($urandom()); C = N'($urandom());
            #1;
            if (in_ready !== 1'b1) not_ready++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (not_ready != 0) begin
            errors++; $display("FAIL stream_throughput: got %0d stalled cycles, required 0", not_ready);
        end
        tick();
        tick();
        checks++;
        if (pops - start_pops != 64 || sb.size() != 0) begin
            errors++;
            $display("FAIL stream_count: got %0d results (%0d pending), required 64 (0 pending)",
                     pops - start_pops, sb.size());
        end
        n = 0;
        while (out_valid && n < 10) begin
            tick();
            n++;
        end
    endtask

    task automatic test_random_ready();
        logic fired;
        int n;
        fired = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (fired || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                A = N'($urandom()); B = N'($urandom()); C = N'($urandom());
                if ($urandom_range(0, 7) == 0) begin
                    A = 16'h8000; B = 16'h7FFF; C = 16'h7FFF;
                end
            end
            out_ready = ($urandom_range(0, 1) != 0);
            #1;
            fired = in_valid && in_ready;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((out_valid || sb.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: got %0d pending v=%b, required 0 pending v=0", sb.size(), out_valid);
        end
    endtask

    task automatic test_mid_reset();
        int stale;
        out_ready = 1'b0;
        in_valid = 1'b1; A = 16'd9; B = 16'd4; C = 16'd1;
        tick();
        A = 16'd50; B = 16'd60; C = 16'd70;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_reset_ready: got in_ready=%b, required 0", in_ready);
        end
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        checks++;
        if (out_valid !== 1'b0 || D !== '0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_clear: got v=%b D=%h ovf=%b, required 0/0000/0", out_valid, D, out_ovf);
        end
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++; $display("FAIL mid_reset_stale: got %0d stale cycles, required 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_neg_ovf();
        test_pos_ovf();
        test_backpressure();
        test_stream();
        test_random_ready();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
